// File: rtl/uart_core.sv
// Full-duplex UART: 16x-oversampling receiver and transmitter sharing one tick
// generator, run-time frame format (5-8 data bits, parity, 1/2 stop) and RTS/CTS.
module uart_core #(
    parameter int unsigned CLK_FREQ  = 50_000_000,
    parameter int unsigned BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx,
    input  logic [1:0] data_bit_num,
    input  logic       stop_bit_num,
    input  logic       parity_en,
    input  logic       parity_type,
    output logic [7:0] rx_data,
    output logic       rts_n,
    output logic       rx_done,
    output logic       parity_error,
    input  logic       cts_n,
    output logic       tx,
    input  logic [7:0] tx_data,
    input  logic       start_tx,
    output logic       tx_done
);
    localparam int unsigned DIV   = CLK_FREQ / (BAUD_RATE * 16);
    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    typedef struct packed {
        logic [1:0] dbits;
        logic       stop2;
        logic       par_en;
        logic       par_odd;
    } frame_cfg_t;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_DONE
    } rx_state_t;

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP, TX_DONE
    } tx_state_t;

    function automatic logic [2:0] last_idx(input logic [1:0] dbits);
        return 3'd4 + {1'b0, dbits};
    endfunction

    function automatic logic [7:0] data_mask(input logic [1:0] dbits);
        logic [7:0] m;
        case (dbits)
            2'd0:    m = 8'h1F;
            2'd1:    m = 8'h3F;
            2'd2:    m = 8'h7F;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

    frame_cfg_t cfg_in;
    assign cfg_in = '{dbits: data_bit_num, stop2: stop_bit_num,
                      par_en: parity_en, par_odd: parity_type};

    // Shared 16x-baud tick
    logic [DIV_W-1:0] div_cnt;
    logic             tick;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
            tick    <= 1'b0;
        end else if (div_cnt == DIV_W'(DIV - 1)) begin
            div_cnt <= '0;
            tick    <= 1'b1;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
            tick    <= 1'b0;
        end
    end

    // ---------------- Receiver ----------------
    logic       rx_meta, rx_sync, rx_prev, rx_fall;
    rx_state_t  rx_state, rx_state_next;
    frame_cfg_t rx_cfg;
    logic [3:0] rx_tick_cnt;
    logic [2:0] rx_bit_idx;
    logic       rx_stop_idx;
    logic [7:0] rx_shift;
    logic       rx_par_bit;
    logic       rx_mid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign rx_fall = rx_prev & ~rx_sync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rx_state <= RX_IDLE;
        else          rx_state <= rx_state_next;
    end

    // Start bit is checked at its middle (8 ticks); every later bit 16 ticks on
    always_comb begin
        rx_state_next = rx_state;
        rx_mid        = 1'b0;
        if (tick) begin
            rx_mid = (rx_state == RX_START) ? (rx_tick_cnt == 4'd7)
                                            : (rx_tick_cnt == 4'd15);
        end
        case (rx_state)
            RX_IDLE:   if (rx_fall) rx_state_next = RX_START;
            RX_START:  if (rx_mid) rx_state_next = rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:   if (rx_mid && rx_bit_idx == last_idx(rx_cfg.dbits))
                           rx_state_next = rx_cfg.par_en ? RX_PARITY : RX_STOP;
            RX_PARITY: if (rx_mid) rx_state_next = RX_STOP;
            RX_STOP:   if (rx_mid && rx_stop_idx == rx_cfg.stop2)
                           rx_state_next = RX_DONE;
            RX_DONE:   rx_state_next = RX_IDLE;
            default:   rx_state_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_cfg      <= '0;
            rx_tick_cnt <= '0;
            rx_bit_idx  <= '0;
            rx_stop_idx <= 1'b0;
            rx_shift    <= '0;
            rx_par_bit  <= 1'b0;
        end else begin
            if (rx_state == RX_IDLE) begin
                rx_tick_cnt <= '0;
                rx_bit_idx  <= '0;
                rx_stop_idx <= 1'b0;
                if (rx_fall) begin
                    rx_cfg   <= cfg_in;
                    rx_shift <= '0;
                end
            end else if (tick) begin
                rx_tick_cnt <= rx_mid ? 4'd0 : rx_tick_cnt + 4'd1;
            end
            if (rx_mid) begin
                case (rx_state)
                    RX_DATA: begin
                        rx_shift[rx_bit_idx] <= rx_sync;
                        rx_bit_idx           <= rx_bit_idx + 3'd1;
                    end
                    RX_PARITY: rx_par_bit  <= rx_sync;
                    RX_STOP:   rx_stop_idx <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    // Frame results are published on entry to DONE and held until the next frame
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rts_n        <= 1'b1;
            rx_done      <= 1'b0;
            rx_data      <= '0;
            parity_error <= 1'b0;
        end else begin
            rts_n   <= (rx_state_next != RX_IDLE);
            rx_done <= (rx_state_next == RX_DONE);
            if (rx_state_next == RX_DONE) begin
                rx_data      <= rx_shift;
                parity_error <= rx_cfg.par_en & (^rx_shift ^ rx_par_bit ^ rx_cfg.par_odd);
            end
        end
    end

    // ---------------- Transmitter ----------------
    tx_state_t  tx_state, tx_state_next;
    frame_cfg_t tx_cfg;
    logic [3:0] tx_tick_cnt;
    logic [2:0] tx_bit_idx;
    logic       tx_stop_idx;
    logic [7:0] tx_shift;
    logic       tx_accept, tx_bit_end, tx_line;

    assign tx_accept  = (tx_state == TX_IDLE) & start_tx & ~cts_n;
    assign tx_bit_end = tick & (tx_tick_cnt == 4'd15);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) tx_state <= TX_IDLE;
        else          tx_state <= tx_state_next;
    end

    always_comb begin
        tx_state_next = tx_state;
        tx_line       = 1'b1;
        case (tx_state)
            TX_IDLE: if (tx_accept) tx_state_next = TX_START;
            TX_START: begin
                tx_line = 1'b0;
                if (tx_bit_end) tx_state_next = TX_DATA;
            end
            TX_DATA: begin
                tx_line = tx_shift[tx_bit_idx];
                if (tx_bit_end && tx_bit_idx == last_idx(tx_cfg.dbits))
                    tx_state_next = tx_cfg.par_en ? TX_PARITY : TX_STOP;
            end
            TX_PARITY: begin
                tx_line = ^tx_shift ^ tx_cfg.par_odd;
                if (tx_bit_end) tx_state_next = TX_STOP;
            end
            TX_STOP: if (tx_bit_end && tx_stop_idx == tx_cfg.stop2)
                         tx_state_next = TX_DONE;
            TX_DONE: tx_state_next = TX_IDLE;
            default: tx_state_next = TX_IDLE;
        endcase
    end

    // Payload is masked to N bits at acceptance so the parity XOR ignores unused bits
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_cfg      <= '0;
            tx_tick_cnt <= '0;
            tx_bit_idx  <= '0;
            tx_stop_idx <= 1'b0;
            tx_shift    <= '0;
        end else begin
            if (tx_state == TX_IDLE) begin
                tx_tick_cnt <= '0;
                tx_bit_idx  <= '0;
                tx_stop_idx <= 1'b0;
                if (tx_accept) begin
                    tx_cfg   <= cfg_in;
                    tx_shift <= tx_data & data_mask(data_bit_num);
                end
            end else if (tick) begin
                tx_tick_cnt <= tx_tick_cnt + 4'd1;
            end
            if (tx_bit_end) begin
                case (tx_state)
                    TX_DATA: tx_bit_idx  <= tx_bit_idx + 3'd1;
                    TX_STOP: tx_stop_idx <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx      <= 1'b1;
            tx_done <= 1'b0;
        end else begin
            tx      <= tx_line;
            tx_done <= (tx_state_next == TX_DONE);
        end
    end

endmodule

// File: tb/tb_uart_core.sv
// Directed self-checking bench for uart_core: RX formats, false start, TX with CTS,
// loopback over 16 frame formats and reset in mid-frame.
module tb_uart_core;
    localparam int unsigned CLK_FREQ = 7_372_800;
    localparam int unsigned BAUD     = 115200;
    localparam int unsigned DIV      = CLK_FREQ / (BAUD * 16);
    localparam int          BIT      = 16 * DIV;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       tb_rx = 1'b1;
    logic       loop_en = 1'b0;
    logic       rx_line;
    logic [1:0] data_bit_num = 2'd3;
    logic       stop_bit_num = 1'b0;
    logic       parity_en = 1'b0;
    logic       parity_type = 1'b0;
    logic [7:0] rx_data;
    logic       rts_n, rx_done, parity_error;
    logic       cts_n = 1'b0;
    logic       tx;
    logic [7:0] tx_data = 8'h00;
    logic       start_tx = 1'b0;
    logic       tx_done;

    int passed = 0;
    int total = 0;
    int rx_done_cnt = 0;
    int tx_done_cnt = 0;
    logic rts_mid;

    assign rx_line = loop_en ? tx : tb_rx;

    uart_core #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD)) dut (
        .clk(clk), .reset_n(reset_n), .rx(rx_line),
        .data_bit_num(data_bit_num), .stop_bit_num(stop_bit_num),
        .parity_en(parity_en), .parity_type(parity_type),
        .rx_data(rx_data), .rts_n(rts_n), .rx_done(rx_done),
        .parity_error(parity_error), .cts_n(cts_n), .tx(tx),
        .tx_data(tx_data), .start_tx(start_tx), .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_done === 1'b1) rx_done_cnt++;
        if (tx_done === 1'b1) tx_done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_cfg(input logic [1:0] dbn, input logic s2, input logic pen, input logic podd);
        data_bit_num = dbn;
        stop_bit_num = s2;
        parity_en    = pen;
        parity_type  = podd;
    endtask

    task automatic send_frame(input logic [7:0] d, input int nbits, input logic pen,
                              input logic pbit, input int nstop);
        tb_rx = 1'b0;
        cycles(BIT / 2);
        rts_mid = rts_n;
        cycles(BIT / 2);
        for (int i = 0; i < nbits; i++) begin
            tb_rx = d[i];
            cycles(BIT);
        end
        if (pen) begin
            tb_rx = pbit;
            cycles(BIT);
        end
        tb_rx = 1'b1;
        cycles(BIT * nstop + 4);
    endtask

    task automatic pulse_start();
        start_tx = 1'b1;
        cycles(1);
        start_tx = 1'b0;
    endtask

    task automatic wait_tx_done(input int base, input int budget, input string tag);
        int n;
        n = 0;
        while (tx_done_cnt == base && n < budget) begin
            cycles(1);
            n++;
        end
        if (tx_done_cnt == base) check(tag, 32'(n), 32'(budget + 1));
    endtask

    int         r0, t0;
    logic       tx_low, found;
    logic [11:0] line;
    logic [7:0] d, m;

    initial begin
        // Reset state
        cycles(3);
        check("rts_n_in_reset", 32'(rts_n), 32'd1);
        check("tx_in_reset", 32'(tx), 32'd1);
        reset_n = 1'b1;
        cycles(4);
        check("rts_n_after_reset", 32'(rts_n), 32'd0);
        check("tx_idle", 32'(tx), 32'd1);
        check("rx_data_reset", 32'(rx_data), 32'd0);
        check("perr_reset", 32'(parity_error), 32'd0);
        check("done_reset", 32'({rx_done, tx_done}), 32'd0);

        // RX 8N1
        set_cfg(2'd3, 1'b0, 1'b0, 1'b0);
        r0 = rx_done_cnt;
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1);
        check("8n1_done_cnt", 32'(rx_done_cnt), 32'(r0 + 1));
        check("8n1_data", 32'(rx_data), 32'h A5);
        check("8n1_perr", 32'(parity_error), 32'd0);
        check("8n1_rts_busy", 32'(rts_mid), 32'd1);
        check("8n1_rts_idle", 32'(rts_n), 32'd0);

        // RX 7E1 with wrong then correct parity bit
        set_cfg(2'd2, 1'b0, 1'b1, 1'b0);
        send_frame(8'h35, 7, 1'b1, 1'b1, 1);
        check("7e1_bad_data", 32'(rx_data), 32'h35);
        check("7e1_bad_perr", 32'(parity_error), 32'd1);
        send_frame(8'h35, 7, 1'b1, 1'b0, 1);
        check("7e1_good_data", 32'(rx_data), 32'h35);
        check("7e1_good_perr", 32'(parity_error), 32'd0);
        check("7e1_done_cnt", 32'(rx_done_cnt), 32'(r0 + 3));

        // RX 5O2, then a 3-tick false start
        set_cfg(2'd0, 1'b1, 1'b1, 1'b1);
        send_frame(8'h1F, 5, 1'b1, 1'b0, 2);
        check("5o2_data", 32'(rx_data), 32'h1F);
        check("5o2_perr", 32'(parity_error), 32'd0);
        r0 = rx_done_cnt;
        tb_rx = 1'b0;
        cycles(3 * DIV);
        tb_rx = 1'b1;
        cycles(2 * BIT);
        check("false_start_no_done", 32'(rx_done_cnt), 32'(r0));
        check("false_start_idle", 32'(rts_n), 32'd0);
        check("false_start_data_held", 32'(rx_data), 32'h1F);

        // TX 8O2 gated by CTS
        set_cfg(2'd3, 1'b1, 1'b1, 1'b1);
        tx_data = 8'h3C;
        cts_n = 1'b1;
        t0 = tx_done_cnt;
        pulse_start();
        tx_low = 1'b0;
        repeat (2 * BIT) begin
            cycles(1);
            if (tx !== 1'b1) tx_low = 1'b1;
        end
        check("cts_block_tx", 32'(tx_low), 32'd0);
        check("cts_block_done", 32'(tx_done_cnt), 32'(t0));
        cts_n = 1'b0;
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < BIT && !found; i++) begin
            if (tx === 1'b0) found = 1'b1;
            else cycles(1);
        end
        check("tx_start_seen", 32'(found), 32'd1);
        cycles(BIT / 2);
        line[0] = tx;
        for (int k = 1; k < 12; k++) begin
            cycles(BIT);
            line[k] = tx;
        end
        check("tx_8o2_line", 32'(line), 32'h E78);
        wait_tx_done(t0, 2 * BIT, "tx_done_timeout");
        cycles(BIT);
        check("tx_done_once", 32'(tx_done_cnt), 32'(t0 + 1));

        // Loopback over 16 formats
        loop_en = 1'b1;
        for (int f = 0; f < 16; f++) begin
            set_cfg(2'(f), f[2], f[3], f[0] ^ f[2]);
            d = 8'(8'hA7 + f * 37);
            m = 8'hFF >> (3 - f[1:0]);
            tx_data = d;
            r0 = rx_done_cnt;
            t0 = tx_done_cnt;
            pulse_start();
            wait_tx_done(t0, 16 * BIT, "loop_tx_timeout");
            cycles(4);
            check($sformatf("loop%0d_done", f), 32'(rx_done_cnt), 32'(r0 + 1));
            check($sformatf("loop%0d_data", f), 32'(rx_data), 32'(d & m));
            check($sformatf("loop%0d_perr", f), 32'(parity_error), 32'd0);
        end
        loop_en = 1'b0;

        // Reset during bit 3 of both an RX and a TX frame
        set_cfg(2'd3, 1'b0, 1'b0, 1'b0);
        tx_data = 8'h00;
        r0 = rx_done_cnt;
        t0 = tx_done_cnt;
        pulse_start();
        tb_rx = 1'b0;
        cycles(4 * BIT + BIT / 2);
        check("mid_frame_tx_low", 32'(tx), 32'd0);
        check("mid_frame_rts", 32'(rts_n), 32'd1);
        reset_n = 1'b0;
        tb_rx = 1'b1;
        cycles(2);
        check("reset_tx_high", 32'(tx), 32'd1);
        check("reset_rx_data", 32'(rx_data), 32'd0);
        cycles(2);
        reset_n = 1'b1;
        cycles(3 * BIT);
        check("reset_no_rx_done", 32'(rx_done_cnt), 32'(r0));
        check("reset_no_tx_done", 32'(tx_done_cnt), 32'(t0));
        check("reset_tx_idle", 32'(tx), 32'd1);
        check("reset_rts_idle", 32'(rts_n), 32'd0);
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1);
        check("post_reset_data", 32'(rx_data), 32'h5A);
        check("post_reset_done", 32'(rx_done_cnt), 32'(r0 + 1));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
